// File: rtl/hazard_forward_unit.sv
// Purpose : EX operand forwarding select, ID load-use / multi-cycle hazard stall, one-entry MUL/DIV scoreboard.
// Latency : forwarding and stall are combinational; scoreboard state and stall counter update on the clock edge.
// Backpr. : Stall_o holds PC and IF/ID while Bubble_o inserts a NOP into ID/EX; a stalled MC issue is retried.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   ID_Rs_i / ID_RsUsed_i             ID-stage source registers and per-operand read enables
//   EX_Rs_i, EX_MemRead_i, EX_Rd_i    EX-stage sources, load flag and destination
//   MEM_/WB_RegWrite_i, MEM_/WB_Rd_i  writeback candidates for forwarding
//   MC_Issue_i, MC_Rd_i               ID instruction issuing to the multi-cycle unit
//   Forward_o                         per-operand select: 10 MEM, 01 WB, 00 register file
//   Stall_o, Bubble_o                 hazard hold / NOP insertion (identical)
//   MC_Busy_o, MC_Done_o              multi-cycle unit occupied / last busy cycle
//   Stall_Cnt_o                       saturating count of stalled cycles
module hazard_forward_unit #(
    parameter int NUM_SRC = 2,
    parameter int RA_W    = 5,
    parameter int MC_LAT  = 4,
    parameter int CNT_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_SRC*RA_W-1:0]   ID_Rs_i,
    input  logic [NUM_SRC-1:0]        ID_RsUsed_i,
    input  logic [NUM_SRC*RA_W-1:0]   EX_Rs_i,
    input  logic                      EX_MemRead_i,
    input  logic [RA_W-1:0]           EX_Rd_i,
    input  logic                      MEM_RegWrite_i,
    input  logic [RA_W-1:0]           MEM_Rd_i,
    input  logic                      WB_RegWrite_i,
    input  logic [RA_W-1:0]           WB_Rd_i,
    input  logic                      MC_Issue_i,
    input  logic [RA_W-1:0]           MC_Rd_i,
    output logic [NUM_SRC*2-1:0]      Forward_o,
    output logic                      Stall_o,
    output logic                      Bubble_o,
    output logic                      MC_Busy_o,
    output logic                      MC_Done_o,
    output logic [CNT_W-1:0]          Stall_Cnt_o
);

    // Countdown width; a single-cycle unit still needs one bit.
    localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RA_W-1:0]   pend_rd_q, pend_rd_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [NUM_SRC*2-1:0] fwd;
    logic lu, mc_raw, mc_struct, stall, busy;

    assign busy = (state_q == S_BUSY);

    // Forwarding: youngest producer (MEM) wins over WB; x0 is never forwarded.
    always_comb begin
        fwd = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (MEM_RegWrite_i && (MEM_Rd_i != '0) && (MEM_Rd_i == EX_Rs_i[k*RA_W +: RA_W]))
                fwd[2*k +: 2] = 2'b10;
            else if (WB_RegWrite_i && (WB_Rd_i != '0) && (WB_Rd_i == EX_Rs_i[k*RA_W +: RA_W]))
                fwd[2*k +: 2] = 2'b01;
        end
    end

    // Hazard detection against the load in EX and the pending multi-cycle result.
    always_comb begin
        lu     = 1'b0;
        mc_raw = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ID_RsUsed_i[k] && (ID_Rs_i[k*RA_W +: RA_W] == EX_Rd_i))
                lu = 1'b1;
            if (ID_RsUsed_i[k] && (ID_Rs_i[k*RA_W +: RA_W] == pend_rd_q))
                mc_raw = 1'b1;
        end
        lu        = lu && EX_MemRead_i && (EX_Rd_i != '0);
        mc_raw    = mc_raw && busy && (pend_rd_q != '0);
        // The unit holds one op; a new issue waits until the unit is back to IDLE.
        mc_struct = busy && MC_Issue_i;
        stall     = !rst_i && (lu || mc_raw || mc_struct);
    end

    // Scoreboard next state and saturating stall counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_rd_d   = pend_rd_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (MC_Issue_i && !stall) begin
                    state_d   = S_BUSY;
                    cnt_d     = CW'(MC_LAT - 1);
                    pend_rd_d = MC_Rd_i;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0)
                    cnt_d = cnt_q - CW'(1);
                else
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_rd_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_rd_q   <= pend_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Forward_o   = fwd;
    assign Stall_o     = stall;
    assign Bubble_o    = stall;
    assign MC_Busy_o   = busy;
    assign MC_Done_o   = busy && (cnt_q == '0);
    assign Stall_Cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Purpose : directed bench for hazard_forward_unit (NUM_SRC=2, RA_W=5, MC_LAT=4, CNT_W=4).
// Latency : inputs driven 2 time units after each rising edge, outputs sampled 1 unit later.
// Backpr. : none; every sequence runs a fixed number of cycles.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [9:0]  id_rs, ex_rs;
    logic [1:0]  id_used;
    logic        ex_mr, mem_we, wb_we, mc_issue;
    logic [4:0]  ex_rd, mem_rd, wb_rd, mc_rd;
    logic [3:0]  fwd;
    logic        stall, bubble, busy, done;
    logic [3:0]  scnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.NUM_SRC(2), .RA_W(5), .MC_LAT(4), .CNT_W(4)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .ID_Rs_i(id_rs), .ID_RsUsed_i(id_used), .EX_Rs_i(ex_rs),
        .EX_MemRead_i(ex_mr), .EX_Rd_i(ex_rd),
        .MEM_RegWrite_i(mem_we), .MEM_Rd_i(mem_rd),
        .WB_RegWrite_i(wb_we), .WB_Rd_i(wb_rd),
        .MC_Issue_i(mc_issue), .MC_Rd_i(mc_rd),
        .Forward_o(fwd), .Stall_o(stall), .Bubble_o(bubble),
        .MC_Busy_o(busy), .MC_Done_o(done), .Stall_Cnt_o(scnt)
    );

    typedef struct {
        logic       mem_we; logic [4:0] mem_rd;
        logic       wb_we;  logic [4:0] wb_rd;
        logic [4:0] ex_rs0; logic [4:0] ex_rs1;
        logic       ex_mr;  logic [4:0] ex_rd;
        logic [4:0] id_rs0; logic [4:0] id_rs1; logic [1:0] id_used;
        logic [3:0] exp_fwd; logic exp_stall;
    } vec_t;

    vec_t tv [11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        id_rs = '0; ex_rs = '0; id_used = '0; ex_mr = 1'b0; ex_rd = '0;
        mem_we = 1'b0; mem_rd = '0; wb_we = 1'b0; wb_rd = '0;
        mc_issue = 1'b0; mc_rd = '0;
    endtask

    // Leaves the bench two units into the first non-reset cycle ("cycle 0").
    task automatic reset_dut();
        rst_i = 1'b1;
        clr();
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask

    initial begin
        // fields: mem_we mem_rd wb_we wb_rd ex_rs0 ex_rs1 ex_mr ex_rd id_rs0 id_rs1 id_used fwd stall
        tv[0]  = '{1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 4'b0010, 1'b0};
        tv[1]  = '{1'b1, 5'd3, 1'b1, 5'd6, 5'd3, 5'd6, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 4'b0110, 1'b0};
        tv[2]  = '{1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 4'b0000, 1'b0};
        tv[3]  = '{1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 4'b0101, 1'b0};
        tv[4]  = '{1'b1, 5'd4, 1'b1, 5'd4, 5'd9, 5'd4, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 4'b1000, 1'b0};
        tv[5]  = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd2, 5'd7, 2'b01, 4'b0000, 1'b0};
        tv[6]  = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd2, 5'd7, 2'b11, 4'b0000, 1'b1};
        tv[7]  = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b11, 4'b0000, 1'b0};
        tv[8]  = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd7, 5'd7, 5'd0, 2'b11, 4'b0000, 1'b0};
        tv[9]  = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd7, 5'd3, 2'b01, 4'b0000, 1'b1};
        tv[10] = '{1'b1, 5'd7, 1'b0, 5'd0, 5'd7, 5'd7, 1'b1, 5'd7, 5'd0, 5'd7, 2'b10, 4'b1010, 1'b1};

        // Reset state; stall forced low during reset, forwarding still live.
        rst_i = 1'b1;
        clr();
        cyc();
        ex_mr = 1'b1; ex_rd = 5'd7; id_rs = {5'd7, 5'd7}; id_used = 2'b11;
        mem_we = 1'b1; mem_rd = 5'd5; ex_rs = {5'd0, 5'd5};
        #1;
        check("rst_stall", stall, 0);
        check("rst_bubble", bubble, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", scnt, 0);
        check("rst_fwd", fwd, 4'b0010);

        // Combinational forwarding / load-use table.
        reset_dut();
        for (int i = 0; i < 11; i++) begin
            mem_we = tv[i].mem_we; mem_rd = tv[i].mem_rd;
            wb_we  = tv[i].wb_we;  wb_rd  = tv[i].wb_rd;
            ex_rs  = {tv[i].ex_rs1, tv[i].ex_rs0};
            ex_mr  = tv[i].ex_mr;  ex_rd  = tv[i].ex_rd;
            id_rs  = {tv[i].id_rs1, tv[i].id_rs0};
            id_used = tv[i].id_used;
            #1;
            check($sformatf("tv%0d_fwd", i), fwd, tv[i].exp_fwd);
            check($sformatf("tv%0d_stall", i), stall, tv[i].exp_stall);
            check($sformatf("tv%0d_bubble", i), bubble, tv[i].exp_stall);
            cyc();
        end

        // Load-use counter increment.
        reset_dut();
        ex_mr = 1'b1; ex_rd = 5'd7; id_rs = {5'd7, 5'd2}; id_used = 2'b01;
        #1;
        check("lu_unused_stall", stall, 0);
        cyc();
        check("lu_cnt0", scnt, 0);
        id_used = 2'b11;
        #1;
        check("lu_used_stall", stall, 1);
        cyc();
        clr();
        #1;
        check("lu_cnt1", scnt, 1);

        // Multi-cycle op, latency 4, dependent reader of x9.
        reset_dut();
        mc_issue = 1'b1; mc_rd = 5'd9;
        #1;
        check("mc_c0_stall", stall, 0);
        check("mc_c0_busy", busy, 0);
        cyc();
        mc_issue = 1'b0; id_rs = {5'd0, 5'd9}; id_used = 2'b01;
        for (int c = 1; c <= 5; c++) begin
            #1;
            check($sformatf("mc_c%0d_busy", c), busy, (c <= 4));
            check($sformatf("mc_c%0d_done", c), done, (c == 4));
            check($sformatf("mc_c%0d_stall", c), stall, (c <= 4));
            cyc();
        end
        check("mc_cnt", scnt, 4);

        // Structural hazard: second issue held from cycle 2.
        reset_dut();
        mc_issue = 1'b1; mc_rd = 5'd9;
        cyc();
        mc_issue = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            mc_issue = (c >= 2 && c <= 5);
            mc_rd = 5'd12;
            #1;
            check($sformatf("st_c%0d_busy", c), busy, (c <= 4) || (c >= 6));
            check($sformatf("st_c%0d_done", c), done, (c == 4) || (c == 9));
            check($sformatf("st_c%0d_stall", c), stall, (c >= 2 && c <= 4));
            cyc();
        end

        // Reset in the middle of an op.
        reset_dut();
        mc_issue = 1'b1; mc_rd = 5'd9;
        cyc();
        mc_issue = 1'b0; id_rs = {5'd0, 5'd9}; id_used = 2'b01;
        #1;
        check("ab_c1_stall", stall, 1);
        cyc();
        rst_i = 1'b1;
        #1;
        check("ab_c2_stall", stall, 0);
        check("ab_c2_busy", busy, 1);
        check("ab_c2_cnt", scnt, 1);
        cyc();
        rst_i = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            #1;
            check($sformatf("ab_c%0d_busy", c), busy, 0);
            check($sformatf("ab_c%0d_done", c), done, 0);
            check($sformatf("ab_c%0d_cnt", c), scnt, 0);
            cyc();
        end

        // Counter saturation, then an x0-destination op.
        reset_dut();
        ex_mr = 1'b1; ex_rd = 5'd7; id_rs = {5'd0, 5'd7}; id_used = 2'b01;
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("sat_%0d", i), scnt, (i < 15) ? i : 15);
            cyc();
        end
        check("sat_end", scnt, 15);
        clr();
        mc_issue = 1'b1; mc_rd = 5'd0;
        #1;
        check("x0_issue_stall", stall, 0);
        cyc();
        mc_issue = 1'b0; id_rs = '0; id_used = 2'b11;
        #1;
        check("x0_read_stall", stall, 0);
        check("x0_busy", busy, 1);
        cyc();
        #1;
        check("x0_read_stall2", stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
